// File: rtl/varset_apply_pkg.sv
// Shared types and status word layout for the varset commit stage.
package varset_apply_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam int unsigned STS_PENDING = 0;
  localparam int unsigned STS_TIMEOUT = 1;
  localparam int unsigned STS_VALID   = 2;

  localparam int unsigned OVR_LSB   = 8;
  localparam int unsigned OVR_MSB   = 15;
  localparam int unsigned APPLY_LSB = 16;
  localparam int unsigned APPLY_MSB = 31;
  localparam int unsigned OVR_W     = OVR_MSB - OVR_LSB + 1;
  localparam int unsigned APPLY_W   = APPLY_MSB - APPLY_LSB + 1;
  localparam int unsigned STS_W     = 32;

endpackage

// File: rtl/varset_apply_bank.sv
// Shadow/active register pair: capture loads shadow from the CPU, commit copies shadow to active.
module varset_apply_bank #(
  parameter int unsigned NREG = 60,
  parameter int unsigned DW   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_capture,
  input  logic                 i_commit,
  input  logic [NREG*DW-1:0]   i_reg,
  output logic [NREG*DW-1:0]   o_active
);

  localparam int unsigned W = NREG * DW;

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_active;

  // Commit reads the pre-capture shadow when both fire together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_capture) r_shadow <= i_reg;
      if (i_commit)  r_active <= r_shadow;
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/varset_apply.sv
// Double-buffered CPU parameter commit: snapshot on trigger, apply on loop sample boundary.
module varset_apply
  import varset_apply_pkg::*;
#(
  parameter int unsigned NREG        = 60,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREG*DW-1:0]   i_reg,
  input  logic                 i_latch_trigger,
  input  logic                 i_sample_tick,
  input  logic                 i_status_clr,
  output logic [NREG*DW-1:0]   o_param,
  output logic                 o_param_valid,
  output logic                 o_apply_pulse,
  output logic [STS_W-1:0]     o_status
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             r_state;
  logic               r_trig_d;
  logic [TW-1:0]      r_timer;
  logic               r_valid;
  logic               r_pulse;
  logic               r_timeout;
  logic [OVR_W-1:0]   r_ovr;
  logic [APPLY_W-1:0] r_apply;

  logic w_trig_edge;
  logic w_pending;
  logic w_timer_hit;
  logic w_commit;
  logic w_timeout_set;
  logic w_overrun;
  logic [STS_W-1:0] w_status;

  assign w_trig_edge   = i_latch_trigger & ~r_trig_d;
  assign w_pending     = (r_state == ST_PENDING);
  assign w_timer_hit   = w_pending && (r_timer == TW'(TIMEOUT_CYC - 1));
  assign w_commit      = w_pending && (i_sample_tick || w_timer_hit);
  // A tick arriving on the last timer cycle is an ordinary commit, not a timeout.
  assign w_timeout_set = w_timer_hit && !i_sample_tick;
  assign w_overrun     = w_pending && w_trig_edge && !w_commit;

  varset_apply_bank #(
    .NREG (NREG),
    .DW   (DW)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_capture (w_trig_edge),
    .i_commit  (w_commit),
    .i_reg     (i_reg),
    .o_active  (o_param)
  );

  // trig_d resets high so a trigger held across reset release is not taken as an edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_trig_d  <= 1'b1;
      r_timer   <= '0;
      r_valid   <= 1'b0;
      r_pulse   <= 1'b0;
      r_timeout <= 1'b0;
      r_ovr     <= '0;
      r_apply   <= '0;
    end else begin
      r_trig_d  <= i_latch_trigger;
      r_pulse   <= w_commit;
      r_timeout <= (r_timeout & ~i_status_clr) | w_timeout_set;

      if (w_commit) begin
        r_valid <= 1'b1;
        r_apply <= r_apply + APPLY_W'(1);
      end

      if (i_status_clr)
        r_ovr <= w_overrun ? OVR_W'(1) : '0;
      else if (w_overrun && (r_ovr != '1))
        r_ovr <= r_ovr + OVR_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_trig_edge) begin
            r_state <= ST_PENDING;
            r_timer <= '0;
          end
        end
        ST_PENDING: begin
          if (w_commit) begin
            r_timer <= '0;
            r_state <= w_trig_edge ? ST_PENDING : ST_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_status                      = '0;
    w_status[STS_PENDING]         = w_pending;
    w_status[STS_TIMEOUT]         = r_timeout;
    w_status[STS_VALID]           = r_valid;
    w_status[OVR_MSB:OVR_LSB]     = r_ovr;
    w_status[APPLY_MSB:APPLY_LSB] = r_apply;
  end

  assign o_param_valid = r_valid;
  assign o_apply_pulse = r_pulse;
  assign o_status      = w_status;

endmodule
